// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder slice walks the operands LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_c,
  output logic carry_c
);
  assign sum_c   = a_i ^ b_i;
  assign carry_c = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             busy_q, done_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Shared full-adder slice: two half adders plus an OR of their carries
  logic s0, c0, s_bit, c1, c_out;

  half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .sum_c(s0),    .carry_c(c0));
  half_adder u_ha1 (.a_i(s0),     .b_i(cy_q),   .sum_c(s_bit), .carry_c(c1));

  assign c_out = c0 | c1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath; IDLE and DONE share the operand-capture path
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d = {s_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = c_out;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          carry_d = c_out;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = cy_q ^ c_out;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, random ops
// against an arithmetic model, and hand sequences for abort/ignore/back-to-back.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, carry;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] prev_sum;
  logic         prev_carry;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] esum;
    logic         ecarry;
    logic         eovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one addition from IDLE; optionally pokes start with junk operands mid-run
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [W-1:0] esum, input logic ecarry, input int poke);
    int edges, busy_n, held_bad;
    start = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    edges = 0; busy_n = 0; held_bad = 0;
    while (!done && edges < 20) begin
      if (busy) busy_n++;
      if (sum !== prev_sum || carry !== prev_carry) held_bad++;
      if (edges == poke) begin
        start = 1'b1; a = '1; b = '1;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check("latency", 32'(edges), 32'(W));
    check("busy_cycles", 32'(busy_n), 32'(W));
    check("sum_held_during_run", 32'(held_bad), 32'd0);
    check("done", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("sum", 32'(sum), 32'(esum));
    check("carry", 32'(carry), 32'(ecarry));
    prev_sum   = esum;
    prev_carry = ecarry;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("sum_hold_after", 32'(sum), 32'(esum));
  endtask

  initial begin
    int dn, edges;
    logic [W:0] ref_full;
    logic [W-1:0] ra, rb;

    vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
    prev_sum = '0; prev_carry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(overflow), 32'd0);
`endif
    rst = 1'b0;

    // Table vectors; first one starts in the cycle right after reset release
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].esum, vecs[i].ecarry, -1);
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", 32'(overflow), 32'(vecs[i].eovf));
`endif
    end

    // Start pulse in the third RUN cycle must be ignored
    do_op(8'h12, 8'h34, 8'h46, 1'b0, 2);

    // Random operands, random ignored pokes, checked against plain arithmetic
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb};
      do_op(ra, rb, ref_full[W-1:0], ref_full[W], int'($urandom_range(0, 9)) - 1);
`ifdef SERIAL_ADDER_OVF_EN
      check("rand_ovf", 32'(overflow),
            32'((ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1])));
`endif
    end

    // Reset mid-run aborts without a done pulse
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    prev_sum = '0; prev_carry = 1'b0;
    do_op(8'h01, 8'h02, 8'h03, 1'b0, -1);

    // Back-to-back: start held high, new operands presented in DONE
    start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b2b_first_latency", 32'(edges), 32'(W));
    check("b2b_first_sum", 32'(sum), 32'h02);
    a = 8'h02; b = 8'h02;
    @(posedge clk); #1;
    check("b2b_rerun_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    start = 1'b0;
    edges = 1;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b2b_done_spacing", 32'(edges), 32'(W + 1));
    check("b2b_second_sum", 32'(sum), 32'h04);
    check("b2b_second_carry", 32'(carry), 32'd0);
    @(posedge clk); #1;
    check("b2b_idle", 32'(done | busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to add a and b; sampled only when not busy.
REQ-005 SHALL have port: a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; sum/carry valid.
REQ-009 SHALL have port: sum  output  WIDTH  result a+b modulo 2^WIDTH, held until next done.
REQ-010 SHALL have port: carry  output  1  carry-out of bit WIDTH-1, held with sum.

Function
REQ-011 SHALL compute bit-serially, LSB first, one bit per cycle, through one shared full-adder slice built from two Half_Adder instances plus an OR of their carries.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 -> capture a, b into shift registers, clear carry flop and bit counter, go RUN; else stay.
REQ-014 RUN: each cycle add current LSBs with carry flop, shift result bit into result register MSB, shift operands right, increment counter; after bit WIDTH-1 go DONE.
REQ-015 DONE: done=1 for exactly this cycle; sum and carry update from result register and carry flop on entry to DONE.
REQ-016 DONE with start=1 SHALL capture new operands and go directly to RUN (back-to-back); else go IDLE.
REQ-017 Latency SHALL be fixed: start accepted at edge N -> done high in cycle N+WIDTH+1, independent of operand values.
REQ-018 busy SHALL be 1 in RUN only; 0 in IDLE and DONE.
REQ-019 start while busy=1 SHALL be ignored; a, b changes during RUN SHALL not affect the result.
REQ-020 Bit counter SHALL be ceil(log2(WIDTH))+1 bits and never wrap during an operation.
REQ-021 sum/carry SHALL change only in the cycle done is asserted (or on reset).

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, sum=0, carry=0, clear operand/result registers, carry flop and counter.
REQ-023 rst asserted mid-RUN SHALL abort the operation with no done pulse; rst dominates start in the same cycle.
REQ-024 First start SHALL be accepted in the cycle after rst deasserts.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN SHALL, when defined, add output port overflow (1 bit): signed two's-complement overflow = carry into MSB XOR carry out of MSB, updated and held with sum, reset to 0.
REQ-026 Without SERIAL_ADDER_OVF_EN the overflow port and its logic SHALL not exist; all other behaviour identical.

Verification (WIDTH=8)
REQ-027 Reset, start with a=0x0F, b=0x01 -> busy for 8 cycles, done at start+9, sum=0x10, carry=0.
REQ-028 a=0xFF, b=0x01 -> sum=0x00, carry=1; a=0x00, b=0x00 -> sum=0x00, carry=0, same latency.
REQ-029 With SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01 -> sum=0x80, carry=0, overflow=1; a=0x80, b=0x80 -> sum=0x00, carry=1, overflow=1.
REQ-030 Start a=0x12, b=0x34; at cycle 3 pulse start with a=0xFF, b=0xFF -> ignored, result sum=0x46, carry=0.
REQ-031 Start a=0xAA, b=0x55; assert rst at cycle 4 -> no done, sum=0, carry=0; next start a=0x01, b=0x02 -> sum=0x03.
REQ-032 Hold start=1 with a=0x01, b=0x01 then a=0x02, b=0x02 at DONE -> two done pulses 9 cycles apart, sums 0x02 then 0x04.
